// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
package fetch_pkg;

    // Default instruction-memory word-address width
    localparam int DEF_ADDR_W = 10;

    // Default instruction word width
    localparam int DEF_DATA_W = 32;

    // All-zero NOP encoding; it travels through the queue like any other word
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // One prefetch-queue entry: the word address and the instruction fetched from it
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr;
    } fetch_entry_t;

    // Increment a 32-bit counter, sticking at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: synchronous FIFO of fetch entries, QDEPTH deep.
// The head entry is visible combinationally; flush empties the queue and wins over push.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  QDEPTH  = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  entry_t                    push_data_i,
    input  logic                      pop_i,
    output logic [$clog2(QDEPTH):0]   count_o,
    output entry_t                    head_o
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_s;
    logic             pop_s;
    entry_t           mem_q [QDEPTH];

    // Qualify push/pop against occupancy and compute next pointers and count
    always_comb begin
        pop_s    = pop_i && (count_q != CNT_W'(0));
        push_s   = push_i && ((count_q != CNT_W'(QDEPTH)) || pop_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = CNT_W'(0);
        end else begin
            // Pointers wrap naturally because QDEPTH is a power of two
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; a push coinciding with a flush is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads to a synchronous instruction memory,
// queues the returned words with their addresses and hands them to decode over
// a valid/ready handshake. A redirect flushes everything and restarts at a new pc.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int QDEPTH   = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] req_addr_q;
    logic              inflight_q;
    logic              kill_q;
    logic              req_s;
    logic              push_s;
    logic              pop_s;
    logic              out_valid_s;
    logic [CNT_W-1:0]  count_s;
    logic [CNT_W:0]    credit_need_s;
    logic [CNT_W:0]    credit_room_s;
    entry_t            head_s;
    entry_t            push_entry_s;
    entry_t            hold_q;

    // Decode-side handshake and capture of the memory response
    always_comb begin
        out_valid_s        = (count_s != CNT_W'(0));
        pop_s              = out_valid_s && out_ready;
        // A response belonging to a request made before a redirect is never queued
        push_s             = inflight_q && !kill_q && !redirect;
        push_entry_s.pc    = req_addr_q;
        push_entry_s.instr = imem_rdata;
    end

    // Credit check: a request may only go out if its response is guaranteed a slot
    always_comb begin
        credit_need_s = (CNT_W+1)'(count_s) + (CNT_W+1)'(inflight_q) + (CNT_W+1)'(1);
        credit_room_s = (CNT_W+1)'(QDEPTH) - (CNT_W+1)'(pop_s);
        if (reset && fetch_en && !redirect && (credit_need_s <= credit_room_s)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    // Next fetch pc: redirect first, otherwise advance on each request (wraps at 2^ADDR_W)
    always_comb begin
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (req_s) begin
            pc_d = pc_q + ADDR_W'(1);
        end else begin
            pc_d = pc_q;
        end
    end

    // Fetch pc, in-flight tracking and the post-redirect kill window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= ADDR_W'(RESET_PC);
            req_addr_q <= ADDR_W'(0);
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= req_s;
            kill_q     <= redirect;
            if (req_s) begin
                req_addr_q <= pc_q;
            end else begin
                req_addr_q <= req_addr_q;
            end
        end
    end

    // Remember the last head shown so outputs hold steady while the queue is empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q.pc    <= ADDR_W'(0);
            hold_q.instr <= DATA_W'(NOP_WORD);
        end else if (out_valid_s) begin
            hold_q <= head_s;
        end else begin
            hold_q <= hold_q;
        end
    end

    fetch_queue #(
        .QDEPTH  (QDEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk         (clk),
        .rst_n       (reset),
        .flush_i     (redirect),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .count_o     (count_s),
        .head_o      (head_s)
    );

    assign imem_req  = req_s;
    assign imem_addr = pc_q;
    assign out_valid = out_valid_s;
    assign out_instr = out_valid_s ? head_s.instr : hold_q.instr;
    assign out_pc    = out_valid_s ? head_s.pc    : hold_q.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Saturating counts of delivered instructions and decode-starved cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= 32'd0;
            perf_stall_q   <= 32'd0;
        end else begin
            if (pop_s) begin
                perf_fetched_q <= sat_inc32(perf_fetched_q);
            end else begin
                perf_fetched_q <= perf_fetched_q;
            end
            if (out_ready && !out_valid_s && fetch_en) begin
                perf_stall_q <= sat_inc32(perf_stall_q);
            end else begin
                perf_stall_q <= perf_stall_q;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
